// File: rtl/axis_packet_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// axis_packet_arbiter_pkg
// Shared definitions for the packet arbiter: FSM state encoding, the
// packet-counter width, the default beat width and the counter increment
// helper.
// ----------------------------------------------------------------------------
package axis_packet_arbiter_pkg;

    // Arbiter FSM states; the encodings are fixed so debug tooling can decode them.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam int CNT_W             = 32;
    localparam int DEFAULT_BYTEWIDTH = 4;

    // Packet counter increment; wraps from all-ones back to zero.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] value);
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/axis_rr_select.sv
// ----------------------------------------------------------------------------
// axis_rr_select
// Combinational round-robin picker. Starting after the last granted index,
// it returns the first requesting input, searching modulo C_NUM_INPUTS.
// Ports:
//   req        in  C_NUM_INPUTS  request vector, bit i = input i
//   last_grant in  C_GRANT_W     index granted most recently
//   next_grant out C_GRANT_W     winning index (last_grant if nobody requests)
//   any_req    out 1             at least one request is present
// ----------------------------------------------------------------------------
module axis_rr_select #(
    parameter int C_NUM_INPUTS = 2,
    parameter int C_GRANT_W    = 3
) (
    input  logic [C_NUM_INPUTS-1:0] req,
    input  logic [C_GRANT_W-1:0]    last_grant,
    output logic [C_GRANT_W-1:0]    next_grant,
    output logic                    any_req
);

    logic found_s;
    int   cand_s;

    // Priority search over last_grant+1 .. last_grant+N; the first hit wins.
    always_comb begin
        next_grant = last_grant;
        found_s    = 1'b0;
        cand_s     = 0;
        any_req    = |req;
        for (int k = 1; k <= C_NUM_INPUTS; k++) begin
            cand_s = (int'(last_grant) + k) % C_NUM_INPUTS;
            for (int j = 0; j < C_NUM_INPUTS; j++) begin
                if (!found_s && (j == cand_s) && req[j]) begin
                    next_grant = C_GRANT_W'(j);
                    found_s    = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// ----------------------------------------------------------------------------
// axis_packet_arbiter
// Packet-level round-robin arbiter that shares one AXI4-Stream output between
// C_NUM_INPUTS inputs. A grant lasts from the first beat through the TLAST
// beat, so packets never interleave. The data path is combinational; only the
// grant, the state and the packet counter are registered.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   enable                      allow new grants (sampled only while idle)
//   input_s_axis_*              concatenated input streams, input i in slice i
//   output_m_axis_*             shared output stream
//   grant_idx                   current or last granted input
//   busy                        high while a packet grant is held
//   pkt_count                   TLAST handshakes seen on the output (wrapping)
// ----------------------------------------------------------------------------
module axis_packet_arbiter
    import axis_packet_arbiter_pkg::*;
#(
    parameter int C_AXIS_BYTEWIDTH = DEFAULT_BYTEWIDTH,
    parameter int C_NUM_INPUTS     = 2,
    parameter int C_GRANT_W        = 3
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic                                    enable,
    input  logic [C_NUM_INPUTS-1:0]                 input_s_axis_tvalid,
    input  logic [C_NUM_INPUTS*8*C_AXIS_BYTEWIDTH-1:0] input_s_axis_tdata,
    input  logic [C_NUM_INPUTS*C_AXIS_BYTEWIDTH-1:0]   input_s_axis_tstrb,
    input  logic [C_NUM_INPUTS-1:0]                 input_s_axis_tlast,
    output logic [C_NUM_INPUTS-1:0]                 input_s_axis_tready,
    output logic                                    output_m_axis_tvalid,
    output logic [8*C_AXIS_BYTEWIDTH-1:0]           output_m_axis_tdata,
    output logic [C_AXIS_BYTEWIDTH-1:0]             output_m_axis_tstrb,
    output logic                                    output_m_axis_tlast,
    input  logic                                    output_m_axis_tready,
    output logic [C_GRANT_W-1:0]                    grant_idx,
    output logic                                    busy,
    output logic [CNT_W-1:0]                        pkt_count
);

    localparam int DW = 8 * C_AXIS_BYTEWIDTH;
    localparam int SW = C_AXIS_BYTEWIDTH;

    arb_state_t             state_r;
    logic [C_GRANT_W-1:0]   grant_idx_r;
    logic [CNT_W-1:0]       pkt_count_r;
    logic [C_GRANT_W-1:0]   next_grant_s;
    logic                   any_req_s;
    logic                   last_hs_s;

    axis_rr_select #(
        .C_NUM_INPUTS (C_NUM_INPUTS),
        .C_GRANT_W    (C_GRANT_W)
    ) u_rr_select (
        .req        (input_s_axis_tvalid),
        .last_grant (grant_idx_r),
        .next_grant (next_grant_s),
        .any_req    (any_req_s)
    );

    // Zero-latency mux: granted input to output, output tready back to the granted input only.
    always_comb begin
        output_m_axis_tvalid = 1'b0;
        output_m_axis_tdata  = {DW{1'b0}};
        output_m_axis_tstrb  = {SW{1'b0}};
        output_m_axis_tlast  = 1'b0;
        input_s_axis_tready  = {C_NUM_INPUTS{1'b0}};
        if (state_r == ST_GRANT) begin
            for (int i = 0; i < C_NUM_INPUTS; i++) begin
                if (grant_idx_r == C_GRANT_W'(i)) begin
                    output_m_axis_tvalid   = input_s_axis_tvalid[i];
                    output_m_axis_tdata    = input_s_axis_tdata[i*DW +: DW];
                    output_m_axis_tstrb    = input_s_axis_tstrb[i*SW +: SW];
                    output_m_axis_tlast    = input_s_axis_tlast[i];
                    input_s_axis_tready[i] = output_m_axis_tready;
                end else begin
                    input_s_axis_tready[i] = 1'b0;
                end
            end
        end else begin
            input_s_axis_tready = {C_NUM_INPUTS{1'b0}};
        end
    end

    // End of packet: TLAST beat accepted by the downstream sink.
    always_comb begin
        last_hs_s = output_m_axis_tvalid & output_m_axis_tready & output_m_axis_tlast;
    end

    // Arbiter FSM with grant register and packet counter. A reset abandons any
    // partial packet; downstream then sees a truncated packet.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            grant_idx_r <= C_GRANT_W'(C_NUM_INPUTS - 1);
            pkt_count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable && any_req_s) begin
                        grant_idx_r <= next_grant_s;
                        state_r     <= ST_GRANT;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    // enable is deliberately ignored here so a packet is never cut short.
                    if (last_hs_s) begin
                        pkt_count_r <= cnt_inc(pkt_count_r);
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_GRANT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Status outputs come straight from registers.
    always_comb begin
        grant_idx = grant_idx_r;
        busy      = (state_r == ST_GRANT);
        pkt_count = pkt_count_r;
    end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axis_packet_arbiter
// Directed bench for axis_packet_arbiter (2 inputs, 4-byte beats). Each input
// is fed from a queue of beats. A packet-level model (busy flag, granted
// index, packet count) predicts every output on every cycle, and the captured
// output beat sequence is compared against hand-written literal lists.
// ----------------------------------------------------------------------------
module tb_axis_packet_arbiter;

    localparam int N  = 2;
    localparam int BW = 4;
    localparam int DW = 32;
    localparam int GW = 3;

    logic            clk = 1'b0;
    logic            resetn;
    logic            enable;
    logic [N-1:0]    in_tvalid;
    logic [N*DW-1:0] in_tdata;
    logic [N*BW-1:0] in_tstrb;
    logic [N-1:0]    in_tlast;
    logic [N-1:0]    in_tready;
    logic            out_tvalid;
    logic [DW-1:0]   out_tdata;
    logic [BW-1:0]   out_tstrb;
    logic            out_tlast;
    logic            out_tready;
    logic [GW-1:0]   grant_idx;
    logic            busy;
    logic [31:0]     pkt_count;

    always #5 clk = ~clk;

    axis_packet_arbiter #(
        .C_AXIS_BYTEWIDTH (BW),
        .C_NUM_INPUTS     (N),
        .C_GRANT_W        (GW)
    ) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .enable               (enable),
        .input_s_axis_tvalid  (in_tvalid),
        .input_s_axis_tdata   (in_tdata),
        .input_s_axis_tstrb   (in_tstrb),
        .input_s_axis_tlast   (in_tlast),
        .input_s_axis_tready  (in_tready),
        .output_m_axis_tvalid (out_tvalid),
        .output_m_axis_tdata  (out_tdata),
        .output_m_axis_tstrb  (out_tstrb),
        .output_m_axis_tlast  (out_tlast),
        .output_m_axis_tready (out_tready),
        .grant_idx            (grant_idx),
        .busy                 (busy),
        .pkt_count            (pkt_count)
    );

    // Source queues, entry = {tlast, tdata}.
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [31:0] beats_q[$];

    // Packet-level model.
    bit          m_busy;
    int          m_grant;
    logic [31:0] m_count;
    bit          chk_en;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int i, input logic [31:0] d, input logic l);
        if (i == 0) q0.push_back({l, d});
        else        q1.push_back({l, d});
    endtask

    task automatic drive_inputs();
        logic [32:0] h;
        for (int i = 0; i < N; i++) begin
            int sz;
            sz = (i == 0) ? q0.size() : q1.size();
            h  = 33'd0;
            if (sz > 0) h = (i == 0) ? q0[0] : q1[0];
            in_tvalid[i]         = (sz > 0);
            in_tdata[i*DW +: DW] = h[31:0];
            in_tstrb[i*BW +: BW] = (sz > 0) ? 4'hF : 4'h0;
            in_tlast[i]          = h[32];
        end
    endtask

    // Expected outputs follow directly from the model's busy/grant view.
    task automatic check();
        logic [N-1:0]  e_rdy;
        logic          e_v;
        logic [DW-1:0] e_d;
        logic [BW-1:0] e_s;
        logic          e_l;
        e_rdy = '0;
        e_v = 1'b0; e_d = '0; e_s = '0; e_l = 1'b0;
        if (m_busy) begin
            e_v = in_tvalid[m_grant];
            e_d = in_tdata[m_grant*DW +: DW];
            e_s = in_tstrb[m_grant*BW +: BW];
            e_l = in_tlast[m_grant];
            e_rdy[m_grant] = out_tready;
        end
        chk("tvalid", 64'(out_tvalid), 64'(e_v));
        chk("tdata", 64'(out_tdata), 64'(e_d));
        chk("tstrb", 64'(out_tstrb), 64'(e_s));
        chk("tlast", 64'(out_tlast), 64'(e_l));
        chk("tready", 64'(in_tready), 64'(e_rdy));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("grant_idx", 64'(grant_idx), 64'(m_grant));
        chk("pkt_count", 64'(pkt_count), 64'(m_count));
    endtask

    task automatic model_update();
        bit found;
        int idx;
        if (!resetn) begin
            m_busy  = 1'b0;
            m_grant = N - 1;
            m_count = 32'd0;
        end else if (!m_busy) begin
            if (enable && (in_tvalid != '0)) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_grant + k) % N;
                    if (!found && in_tvalid[idx]) begin
                        m_grant = idx;
                        found   = 1'b1;
                    end
                end
                m_busy = 1'b1;
            end
        end else if (in_tvalid[m_grant] && out_tready && in_tlast[m_grant]) begin
            m_count = m_count + 32'd1;
            m_busy  = 1'b0;
        end
    endtask

    task automatic step();
        logic [N-1:0] hs;
        drive_inputs();
        @(negedge clk);
        if (chk_en) check();
        hs = in_tvalid & in_tready;
        if (out_tvalid && out_tready) beats_q.push_back(out_tdata);
        @(posedge clk);
        model_update();
        #1;
        if (hs[0]) void'(q0.pop_front());
        if (hs[1]) void'(q1.pop_front());
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic chk_beats(input string name, input int n, input logic [31:0] e [8]);
        chk({name, "_nbeats"}, 64'(beats_q.size()), 64'(n));
        for (int k = 0; k < n; k++) begin
            if (k < beats_q.size()) chk({name, "_beat"}, 64'(beats_q[k]), 64'(e[k]));
        end
    endtask

    initial begin
        resetn     = 1'b0;
        enable     = 1'b1;
        out_tready = 1'b1;
        in_tvalid  = '0;
        in_tdata   = '0;
        in_tstrb   = '0;
        in_tlast   = '0;
        m_busy     = 1'b0;
        m_grant    = N - 1;
        m_count    = 32'd0;
        chk_en     = 1'b0;

        // Reset state
        run(2);
        chk_en = 1'b1;
        run(1);
        resetn = 1'b1;
        chk("rst_grant", 64'(grant_idx), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_count", 64'(pkt_count), 64'd0);

        // Single 3-beat packet on input 0
        beats_q.delete();
        push(0, 32'h11, 1'b0); push(0, 32'h22, 1'b0); push(0, 32'h33, 1'b1);
        run(5);
        chk_beats("t1", 3, '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0});
        chk("t1_count", 64'(pkt_count), 64'd1);
        chk("t1_grant", 64'(grant_idx), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);

        // Both inputs stream single-beat packets: strict alternation with idle bubbles
        beats_q.delete();
        for (int k = 0; k < 4; k++) begin
            push(0, 32'hA0 + 32'(k), 1'b1);
            push(1, 32'hB0 + 32'(k), 1'b1);
        end
        run(8);
        chk("t2_count_half", 64'(pkt_count), 64'd5);
        run(8);
        chk_beats("t2", 8, '{32'hB0, 32'hA0, 32'hB1, 32'hA1, 32'hB2, 32'hA2, 32'hB3, 32'hA3});
        chk("t2_count", 64'(pkt_count), 64'd9);

        // Input 0 requests while input 1 is mid-packet
        beats_q.delete();
        for (int k = 0; k < 4; k++) push(1, 32'hC0 + 32'(k), (k == 3));
        run(2);
        push(0, 32'hD0, 1'b1);
        run(2);
        chk("t3_rdy0_blocked", 64'(in_tready[0]), 64'd0);
        run(4);
        chk_beats("t3", 5, '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hD0, 32'h0, 32'h0, 32'h0});
        chk("t3_count", 64'(pkt_count), 64'd11);

        // Output backpressure toggling during a 4-beat packet
        beats_q.delete();
        for (int k = 0; k < 4; k++) push(1, 32'hE0 + 32'(k), (k == 3));
        run(1);
        for (int k = 0; k < 8; k++) begin
            out_tready = (k % 2 == 0);
            step();
        end
        out_tready = 1'b1;
        chk_beats("t4", 4, '{32'hE0, 32'hE1, 32'hE2, 32'hE3, 32'h0, 32'h0, 32'h0, 32'h0});
        chk("t4_count", 64'(pkt_count), 64'd12);

        // enable dropped mid-packet: packet completes, then no new grant
        beats_q.delete();
        for (int k = 0; k < 4; k++) push(0, 32'hF0 + 32'(k), (k == 3));
        push(1, 32'h60, 1'b1);
        run(2);
        enable = 1'b0;
        run(7);
        chk("t5_idle_busy", 64'(busy), 64'd0);
        chk("t5_pending", 64'(q1.size()), 64'd1);
        enable = 1'b1;
        run(3);
        chk_beats("t5", 5, '{32'hF0, 32'hF1, 32'hF2, 32'hF3, 32'h60, 32'h0, 32'h0, 32'h0});
        chk("t5_grant", 64'(grant_idx), 64'd1);
        chk("t5_count", 64'(pkt_count), 64'd14);

        // Counter wrap
        force dut.pkt_count_r = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_count_r;
        push(0, 32'h70, 1'b1); push(0, 32'h71, 1'b1);
        run(2);
        chk("t6_wrap0", 64'(pkt_count), 64'd0);
        run(2);
        chk("t6_wrap1", 64'(pkt_count), 64'd1);

        // Reset in the middle of a packet
        beats_q.delete();
        for (int k = 0; k < 4; k++) push(1, 32'h80 + 32'(k), (k == 3));
        run(3);
        resetn = 1'b0;
        step();
        chk("t7_tready", 64'(in_tready), 64'd0);
        chk("t7_tvalid", 64'(out_tvalid), 64'd0);
        chk("t7_busy", 64'(busy), 64'd0);
        chk("t7_count", 64'(pkt_count), 64'd0);
        chk("t7_grant", 64'(grant_idx), 64'd1);
        q1.delete();
        step();
        resetn = 1'b1;
        run(2);
        chk_beats("t7", 3, '{32'h80, 32'h81, 32'h82, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
